// File: rtl/commit_trace_buffer.sv
// commit_trace_buffer: captures register-file write-back events (pc, rd, data)
// into a show-ahead FIFO read over a valid/ready port, and counts run cycles
// up to MAX_CYCLES, after which capture stops and done_o is raised.
// Optional build macro: TRACE_X0_FILTER_EN drops write-backs to x0 before capture.
module commit_trace_buffer #(
    parameter int DEPTH      = 8,
    parameter int MAX_CYCLES = 30
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     wb_valid_i,
    input  logic [31:0]              wb_pc_i,
    input  logic [4:0]               wb_rd_i,
    input  logic [31:0]              wb_data_i,
    output logic                     rd_valid_o,
    input  logic                     rd_ready_i,
    output logic [31:0]              rd_pc_o,
    output logic [4:0]               rd_rd_o,
    output logic [31:0]              rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [31:0]              cycle_o,
    output logic                     overflow_o,
    output logic                     done_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t             mem [DEPTH];

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [31:0]        cycle_q, cycle_d;
    logic               overflow_q, overflow_d;
    logic               done_q, done_d;
    entry_t             head_q, head_d;

    logic               capture_ok;
    logic               run_active;
    logic               push_req;
    logic               push;
    logic               pop;
    logic               full;
    logic [CNT_W-1:0]   remain_old;
    entry_t             wb_entry;

`ifdef TRACE_X0_FILTER_EN
    // Writes to x0 are architecturally invisible, so they are never traced
    assign capture_ok = (wb_rd_i != 5'd0);
`else
    assign capture_ok = 1'b1;
`endif

    assign wb_entry = '{pc: wb_pc_i, rd: wb_rd_i, data: wb_data_i};

    // Next-state logic for run control, FIFO bookkeeping and the head register
    always_comb begin
        run_active = start_i && (state_q != ST_DONE);
        push_req   = run_active && wb_valid_i && capture_ok;
        full       = (count_q == CNT_W'(DEPTH));
        pop        = (count_q != '0) && rd_ready_i;
        // A full FIFO still accepts a push when the head leaves on the same edge
        push       = push_req && (!full || pop);

        wr_ptr_d   = wr_ptr_q + PTR_W'(push);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
        remain_old = count_q - CNT_W'(pop);
        overflow_d = overflow_q || (push_req && full && !pop);

        cycle_d = cycle_q;
        if (run_active && (cycle_q != 32'(MAX_CYCLES))) begin
            cycle_d = cycle_q + 32'd1;
        end

        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end else if (cycle_q == 32'(MAX_CYCLES - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_DONE;
        endcase
        done_d = (state_d == ST_DONE);

        // Show-ahead head: hold when empty, forward the new event when it
        // becomes the only entry, otherwise read the next stored entry
        head_d = head_q;
        if (count_d != '0) begin
            if (remain_old == '0) begin
                head_d = wb_entry;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end
    end

    // Entry storage: written at the tail on every accepted push
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr_q] <= wb_entry;
        end
    end

    // Control state, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            done_q     <= 1'b0;
            head_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            done_q     <= done_d;
            head_q     <= head_d;
        end
    end

    assign rd_valid_o = (count_q != '0);
    assign rd_pc_o    = head_q.pc;
    assign rd_rd_o    = head_q.rd;
    assign rd_data_o  = head_q.data;
    assign count_o    = count_q;
    assign cycle_o    = cycle_q;
    assign overflow_o = overflow_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer with a queue scoreboard.
// Honours TRACE_X0_FILTER_EN in its reference model.
module tb_commit_trace_buffer;

    localparam int DEPTH      = 8;
    localparam int MAX_CYCLES = 30;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        wb_valid_i;
    logic [31:0] wb_pc_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        rd_valid_o;
    logic        rd_ready_i;
    logic [31:0] rd_pc_o;
    logic [4:0]  rd_rd_o;
    logic [31:0] rd_data_o;
    logic [3:0]  count_o;
    logic [31:0] cycle_o;
    logic        overflow_o;
    logic        done_o;

    commit_trace_buffer #(.DEPTH(DEPTH), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .wb_valid_i (wb_valid_i),
        .wb_pc_i    (wb_pc_i),
        .wb_rd_i    (wb_rd_i),
        .wb_data_i  (wb_data_i),
        .rd_valid_o (rd_valid_o),
        .rd_ready_i (rd_ready_i),
        .rd_pc_o    (rd_pc_o),
        .rd_rd_o    (rd_rd_o),
        .rd_data_o  (rd_data_o),
        .count_o    (count_o),
        .cycle_o    (cycle_o),
        .overflow_o (overflow_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    int   n_tests = 0;
    int   n_fail  = 0;
    ent_t m_q[$];
    int   m_cycle;
    bit   m_ovf;
    bit   m_done;
    ent_t m_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit cap_ok(input logic [4:0] rd);
`ifdef TRACE_X0_FILTER_EN
        return rd != 5'd0;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_cycle = 0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        m_last  = '0;
    endtask

    // Compare every observable output against the model
    task automatic chk_state(input string tag);
        chk({tag, "_count"},    32'(count_o),    32'(m_q.size()));
        chk({tag, "_valid"},    32'(rd_valid_o), 32'(m_q.size() != 0));
        chk({tag, "_overflow"}, 32'(overflow_o), 32'(m_ovf));
        chk({tag, "_done"},     32'(done_o),     32'(m_done));
        chk({tag, "_cycle"},    cycle_o,         32'(m_cycle));
        if (m_q.size() != 0) begin
            chk({tag, "_head_pc"},   rd_pc_o,        m_q[0].pc);
            chk({tag, "_head_rd"},   32'(rd_rd_o),   32'(m_q[0].rd));
            chk({tag, "_head_data"}, rd_data_o,      m_q[0].data);
        end else begin
            chk({tag, "_hold_pc"},   rd_pc_o,        m_last.pc);
            chk({tag, "_hold_data"}, rd_data_o,      m_last.data);
        end
    endtask

    // Asynchronous reset applied mid-cycle; outputs checked before any edge
    task automatic do_reset(input string tag);
        start_i    = 1'b0;
        wb_valid_i = 1'b0;
        rd_ready_i = 1'b0;
        rst_i      = 1'b0;
        #1;
        model_clear();
        chk({tag, "_rst_count"}, 32'(count_o),    32'd0);
        chk({tag, "_rst_valid"}, 32'(rd_valid_o), 32'd0);
        chk({tag, "_rst_cycle"}, cycle_o,         32'd0);
        chk({tag, "_rst_ovf"},   32'(overflow_o), 32'd0);
        chk({tag, "_rst_done"},  32'(done_o),     32'd0);
        chk({tag, "_rst_pc"},    rd_pc_o,         32'd0);
        $display("[TB] reset %s cnt=%0d valid=%0d cycle=%0d", tag, count_o, rd_valid_o, cycle_o);
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    // One clock of stimulus; model updated, scoreboard popped on reader handshake
    task automatic step(input string tag, input logic st, input logic wv,
                        input logic [31:0] pc, input logic [4:0] rd,
                        input logic [31:0] dt, input logic rdy);
        bit   run, req, full, pop;
        ent_t e;
        start_i    = st;
        wb_valid_i = wv;
        wb_pc_i    = pc;
        wb_rd_i    = rd;
        wb_data_i  = dt;
        rd_ready_i = rdy;
        full = (m_q.size() == DEPTH);
        pop  = (m_q.size() != 0) && rdy;
        if (pop) begin
            e = m_q.pop_front();
            chk({tag, "_pop_pc"},   rd_pc_o,   e.pc);
            chk({tag, "_pop_data"}, rd_data_o, e.data);
            m_last = e;
        end
        run = st && !m_done;
        req = run && wv && cap_ok(rd);
        if (req) begin
            if (!full || pop) m_q.push_back('{pc: pc, rd: rd, data: dt});
            else              m_ovf = 1'b1;
        end
        if (run && m_cycle != MAX_CYCLES) begin
            m_cycle++;
            if (m_cycle == MAX_CYCLES) m_done = 1'b1;
        end
        @(posedge clk_i);
        @(negedge clk_i);
        chk_state(tag);
        $display("[TB] %s st=%0d wv=%0d pc=%0h rd=%0d rdy=%0d -> cnt=%0d ovf=%0d cyc=%0d done=%0d",
                 tag, st, wv, pc, rd, rdy, count_o, overflow_o, cycle_o, done_o);
    endtask

    initial begin
        rst_i      = 1'b0;
        start_i    = 1'b0;
        wb_valid_i = 1'b0;
        wb_pc_i    = '0;
        wb_rd_i    = '0;
        wb_data_i  = '0;
        rd_ready_i = 1'b0;
        model_clear();
        @(negedge clk_i);

        // Three writes held, then drained in order; then IDLE holds everything
        do_reset("r0");
        step("w0", 1, 1, 32'd0, 5'd5, 32'd10, 0);
        step("w1", 1, 1, 32'd4, 5'd6, 32'd20, 0);
        step("w2", 1, 1, 32'd8, 5'd7, 32'd30, 0);
        chk("three_count", 32'(count_o), 32'd3);
        chk("three_head_rd", 32'(rd_rd_o), 32'd5);
        for (int i = 0; i < 3; i++) step("pop3", 1, 0, 32'd0, 5'd0, 32'd0, 1);
        chk("drained_count", 32'(count_o), 32'd0);
        step("idle0", 0, 1, 32'h100, 5'd9, 32'h55, 1);
        step("idle1", 0, 1, 32'h104, 5'd9, 32'h66, 1);
        step("resume", 1, 1, 32'h108, 5'd3, 32'h77, 1);
        step("thru", 1, 1, 32'h10c, 5'd4, 32'h88, 1);
        step("thru_end", 1, 0, 32'd0, 5'd0, 32'd0, 1);

        // Nine writes into a full FIFO with no reader: ninth dropped
        do_reset("r1");
        for (int i = 0; i < 9; i++)
            step("ovf", 1, 1, 32'(i * 4), 5'(i + 1), 32'(i * 3 + 1), 0);
        chk("ovf_count", 32'(count_o), 32'd8);
        chk("ovf_flag", 32'(overflow_o), 32'd1);
        step("ovf_pop", 1, 0, 32'd0, 5'd0, 32'd0, 1);
        step("ovf_sticky", 1, 0, 32'd0, 5'd0, 32'd0, 0);

        // Reader turns on at the eighth write: no overflow
        do_reset("r2");
        for (int i = 0; i < 9; i++)
            step("noovf", 1, 1, 32'(32'h200 + i * 4), 5'(i + 10), 32'(i + 100), (i >= 7) ? 1'b1 : 1'b0);
        chk("noovf_flag", 32'(overflow_o), 32'd0);

        // Push and pop on the same edge while full
        do_reset("r3");
        for (int i = 0; i < 8; i++)
            step("fill", 1, 1, 32'(32'h300 + i * 4), 5'(i + 1), 32'(i + 200), 0);
        step("full_pp", 1, 1, 32'h3f0, 5'd31, 32'hABCD, 1);
        chk("full_pp_count", 32'(count_o), 32'd8);
        chk("full_pp_ovf", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 8; i++) step("drain8", 1, 0, 32'd0, 5'd0, 32'd0, 1);
        step("drain_last", 0, 0, 32'd0, 5'd0, 32'd0, 1);

        // Write-back to x0
        do_reset("r4");
        step("x0", 1, 1, 32'h40, 5'd0, 32'hDEAD, 0);
`ifdef TRACE_X0_FILTER_EN
        chk("x0_count", 32'(count_o), 32'd0);
`else
        chk("x0_count", 32'(count_o), 32'd1);
        chk("x0_rd", 32'(rd_rd_o), 32'd0);
        chk("x0_data", rd_data_o, 32'hDEAD);
`endif
        step("x0_drain", 1, 0, 32'd0, 5'd0, 32'd0, 1);

        // Asynchronous reset with four entries queued and overflow not set
        do_reset("r5");
        for (int i = 0; i < 4; i++)
            step("pre_rst", 1, 1, 32'(32'h500 + i * 4), 5'(i + 2), 32'(i + 7), 0);
        do_reset("mid");
        step("post_rst", 0, 0, 32'd0, 5'd0, 32'd0, 0);

        // Run to the budget with captures up to and including the last edge
        for (int i = 0; i < 27; i++) step("run", 1, 0, 32'd0, 5'd0, 32'd0, 0);
        for (int i = 0; i < 3; i++)
            step("late", 1, 1, 32'(32'h600 + i * 4), 5'(i + 20), 32'(i + 40), 0);
        chk("late_done", 32'(done_o), 32'd1);
        chk("late_cycle", cycle_o, 32'd30);
        chk("late_count", 32'(count_o), 32'd3);
        for (int i = 0; i < 5; i++)
            step("post_done", 1, 1, 32'(32'h700 + i * 4), 5'(i + 1), 32'(i + 1), 0);
        chk("post_done_count", 32'(count_o), 32'd3);
        for (int i = 0; i < 3; i++) step("done_drain", 1, 0, 32'd0, 5'd0, 32'd0, 1);
        chk("done_drain_count", 32'(count_o), 32'd0);

        // Plain budget run with no write-backs
        do_reset("r6");
        for (int i = 0; i < 30; i++) step("budget", 1, 0, 32'd0, 5'd0, 32'd0, 0);
        chk("budget_cycle", cycle_o, 32'd30);
        chk("budget_done", 32'(done_o), 32'd1);
        chk("budget_valid", 32'(rd_valid_o), 32'd0);
        step("budget_sat", 1, 0, 32'd0, 5'd0, 32'd0, 0);
        chk("budget_sat_cycle", cycle_o, 32'd30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
